// File: rtl/memoria_dados_param.sv
// memoria_dados_param: parametrised single-port data memory with clear sweep, 1/2-cycle read latency and range error.
module memoria_dados_param #(
    parameter int LARGURA_DADO     = 8,
    parameter int LARGURA_END      = 8,
    parameter int PROFUNDIDADE     = 256,
    parameter int LATENCIA_LEITURA = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LARGURA_END-1:0]  endereco,
    input  logic [LARGURA_DADO-1:0] dado,
    input  logic                    EscrMemo,
    input  logic                    LerMemo,
    output logic [LARGURA_DADO-1:0] dadoLido,
    output logic                    valido,
    output logic                    erro,
    output logic                    ocupado
);
    localparam int AW = PROFUNDIDADE > 1 ? $clog2(PROFUNDIDADE) : 1;
    localparam logic LIMPA  = 1'b0;
    localparam logic OCIOSO = 1'b1;
    localparam logic [LARGURA_END:0] PROF = (LARGURA_END+1)'(PROFUNDIDADE);
    localparam logic [LARGURA_END:0] FIM  = (LARGURA_END+1)'(PROFUNDIDADE - 1);

    logic                    r_estado;
    logic [LARGURA_END:0]    r_ptr;
    logic [LARGURA_DADO-1:0] r_mem [PROFUNDIDADE];

    logic                    w_ocioso, w_faixa, w_escr, w_ler, w_erro_l, w_erro_e;
    logic [AW-1:0]           w_idx;
    logic [LARGURA_DADO-1:0] w_dado_lido, w_d;
    logic                    w_v, w_e;

    assign ocupado     = r_estado == LIMPA;
    assign w_ocioso    = r_estado == OCIOSO;
    assign w_faixa     = {1'b0, endereco} < PROF;
    assign w_idx       = AW'(endereco);
    assign w_escr      = w_ocioso & EscrMemo & w_faixa;
    assign w_ler       = w_ocioso & LerMemo;
    // Write-first: a simultaneous write forwards its data to the read.
    assign w_dado_lido = !w_faixa ? '0 : EscrMemo ? dado : r_mem[w_idx];
    assign w_erro_l    = w_ler & !w_faixa;
    // A write-only error; a combined request reports once, with the read.
    assign w_erro_e    = w_ocioso & EscrMemo & !LerMemo & !w_faixa;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= LIMPA;
            r_ptr    <= '0;
        end else if (!w_ocioso) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_ptr == FIM)
                r_estado <= OCIOSO;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!w_ocioso)
                r_mem[AW'(r_ptr)] <= '0;
            else if (w_escr)
                r_mem[w_idx] <= dado;
        end
    end

    generate
        if (LATENCIA_LEITURA == 2) begin : g_lat2
            logic                    r_v1, r_e1;
            logic [LARGURA_DADO-1:0] r_d1;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_v1 <= 1'b0;
                    r_e1 <= 1'b0;
                    r_d1 <= '0;
                end else begin
                    r_v1 <= w_ler;
                    r_e1 <= w_erro_l;
                    r_d1 <= w_dado_lido;
                end
            end
            assign w_v = r_v1;
            assign w_d = r_d1;
            assign w_e = r_e1 | w_erro_e;
        end else begin : g_lat1
            assign w_v = w_ler;
            assign w_d = w_dado_lido;
            assign w_e = w_erro_l | w_erro_e;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            dadoLido <= '0;
            valido   <= 1'b0;
            erro     <= 1'b0;
        end else begin
            valido <= w_v;
            erro   <= w_e;
            if (w_v)
                dadoLido <= w_d;
        end
    end
endmodule

// File: tb/tb_memoria_dados_param.sv
// tb_memoria_dados_param: three configurations (default, latency 2, 16-word/5-bit) driven in lockstep against a cycle model.
module tb_memoria_dados_param;
    logic       clk = 0, reset = 1, escr = 0, ler = 0;
    logic [7:0] endereco = 0, dado = 0;
    logic [7:0] q [3];
    logic       v [3], er [3], oc [3];
    logic [4:0] end2;
    assign end2 = endereco[4:0];

    always #5 clk = ~clk;

    memoria_dados_param u0 (.clk(clk), .reset(reset), .endereco(endereco), .dado(dado), .EscrMemo(escr),
        .LerMemo(ler), .dadoLido(q[0]), .valido(v[0]), .erro(er[0]), .ocupado(oc[0]));
    memoria_dados_param #(.LATENCIA_LEITURA(2)) u1 (.clk(clk), .reset(reset), .endereco(endereco), .dado(dado),
        .EscrMemo(escr), .LerMemo(ler), .dadoLido(q[1]), .valido(v[1]), .erro(er[1]), .ocupado(oc[1]));
    memoria_dados_param #(.LARGURA_END(5), .PROFUNDIDADE(16)) u2 (.clk(clk), .reset(reset), .endereco(end2),
        .dado(dado), .EscrMemo(escr), .LerMemo(ler), .dadoLido(q[2]), .valido(v[2]), .erro(er[2]), .ocupado(oc[2]));

    int total = 0, bad = 0, e = 0;
    int prof [3] = '{256, 256, 16};
    int lat  [3] = '{1, 2, 1};
    int mm [3][256];
    bit sv [3][4], se [3][4];
    logic [7:0] sd [3][4];
    bit busy [3];
    int cnt [3];
    logic [7:0] xd [3];
    bit xv [3], xe [3];

    typedef struct {
        bit w, r;
        logic [7:0] a, d;
        bit ev;
        logic [7:0] ed;
    } vec_t;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[u%0d] @edge %0d: got %0h want %0h", nm, k, e, act, exp);
        end
    endtask

    // Expected outputs are queued into a small slot ring by visible edge, then popped.
    task automatic model(input bit rs, input bit w, input bit r, input logic [7:0] a, input logic [7:0] d);
        for (int k = 0; k < 3; k++) begin
            int ad;
            bit inr;
            ad = (k == 2) ? int'(a) % 32 : int'(a);
            if (rs) begin
                busy[k] = 1; cnt[k] = 0; xd[k] = 0; xv[k] = 0; xe[k] = 0;
                for (int j = 0; j < 4; j++) begin sv[k][j] = 0; se[k][j] = 0; end
            end else begin
                if (busy[k]) begin
                    mm[k][cnt[k]] = 0;
                    cnt[k]++;
                    if (cnt[k] == prof[k]) busy[k] = 0;
                end else begin
                    inr = ad < prof[k];
                    if (w && inr) mm[k][ad] = int'(d);
                    if (r) begin
                        int s;
                        s = (e + lat[k] - 1) % 4;
                        sv[k][s] = 1;
                        sd[k][s] = inr ? 8'(mm[k][ad]) : 8'h00;
                        if (!inr) se[k][s] = 1;
                    end else if (w && !inr) se[k][e % 4] = 1;
                end
                xv[k] = sv[k][e % 4];
                xe[k] = se[k][e % 4];
                if (xv[k]) xd[k] = sd[k][e % 4];
                sv[k][e % 4] = 0;
                se[k][e % 4] = 0;
            end
        end
        e++;
    endtask

    task automatic step(input bit rs, input bit w, input bit r, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        reset = rs; escr = w; ler = r; endereco = a; dado = d;
        model(rs, w, r, a, d);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("valido", k, v[k], xv[k]);
            chk("erro", k, er[k], xe[k]);
            chk("ocupado", k, oc[k], busy[k]);
            chk("dadoLido", k, q[k], xd[k]);
        end
    endtask

    initial begin
        vec_t tab [10];
        int n;
        tab[0] = '{0, 1, 8'h37, 8'h00, 1, 8'h00};
        tab[1] = '{1, 0, 8'h10, 8'hA5, 0, 8'h00};
        tab[2] = '{0, 1, 8'h10, 8'h00, 1, 8'hA5};
        tab[3] = '{0, 0, 8'h00, 8'h00, 0, 8'hA5};
        tab[4] = '{1, 1, 8'h20, 8'h5C, 1, 8'h5C};
        tab[5] = '{0, 1, 8'h20, 8'h00, 1, 8'h5C};
        tab[6] = '{0, 1, 8'h37, 8'h00, 1, 8'h00};
        tab[7] = '{1, 0, 8'h30, 8'h77, 0, 8'h00};
        tab[8] = '{0, 1, 8'h30, 8'h00, 1, 8'h77};
        tab[9] = '{0, 0, 8'h00, 8'h00, 0, 8'h77};

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        n = 0;
        do begin step(0, 0, 0, 0, 0); n++; end while (oc[0] && n < 1000);
        chk("sweep_len", 0, n, 256);

        foreach (tab[i]) begin
            step(0, tab[i].w, tab[i].r, tab[i].a, tab[i].d);
            chk("tab_valido", 0, v[0], tab[i].ev);
            chk("tab_dado", 0, q[0], tab[i].ed);
        end

        step(0, 1, 0, 8'h01, 8'h11);
        step(0, 1, 0, 8'h02, 8'h22);
        step(0, 1, 0, 8'h03, 8'h33);
        step(0, 0, 1, 8'h01, 0); chk("lat2_early", 1, v[1], 0);
        step(0, 0, 1, 8'h02, 0); chk("lat2_v1", 1, v[1], 1); chk("lat2_d1", 1, q[1], 8'h11);
        step(0, 0, 1, 8'h03, 0); chk("lat2_v2", 1, v[1], 1); chk("lat2_d2", 1, q[1], 8'h22);
        step(0, 0, 0, 0, 0);     chk("lat2_v3", 1, v[1], 1); chk("lat2_d3", 1, q[1], 8'h33);
        step(0, 0, 0, 0, 0);     chk("lat2_end", 1, v[1], 0); chk("lat2_hold", 1, q[1], 8'h33);

        step(0, 1, 0, 8'h04, 8'h44);
        step(0, 1, 0, 8'h14, 8'hFF); chk("oor_werr", 2, er[2], 1); chk("oor_wv", 2, v[2], 0);
        step(0, 0, 1, 8'h14, 0);     chk("oor_rerr", 2, er[2], 1); chk("oor_rv", 2, v[2], 1); chk("oor_rd", 2, q[2], 0);
        step(0, 0, 0, 0, 0);         chk("oor_pulse", 2, er[2], 0);
        step(0, 0, 1, 8'h04, 0);     chk("oor_alias", 2, q[2], 8'h44);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 8'(i), 0);
        step(0, 1, 1, 8'h1F, 8'h12); chk("oor_both", 2, er[2], 1);
        step(0, 0, 0, 0, 0);         chk("oor_both_once", 2, er[2], 0);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 199) == 0, 1'($urandom), 1'($urandom), 8'($urandom_range(0, 39)), 8'($urandom));

        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) step(0, 0, 0, 0, 0);
        chk("mid_busy", 0, oc[0], 1);
        step(1, 0, 0, 0, 0);
        n = 0;
        do begin step(0, n == 0, 0, 8'h44, 8'h99); n++; end while (oc[0] && n < 1000);
        chk("restart_len", 0, n, 256);
        step(0, 0, 1, 8'h44, 0);
        chk("drop_v", 0, v[0], 1);
        chk("drop_d", 0, q[0], 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/memoria_dados_param.md
Name: memoria_dados_param

Overview:
Parametrised single-port data memory, the successor to the fixed 8-bit memoria_dados in the processor datapath. Adds configurable data/address width and depth, and a selectable read latency of 1 or 2 cycles with a read-valid strobe. Adds a hardware clear sweep after reset, with a busy flag, and an out-of-range address error flag. It serves the load/store stage; the control unit drives LerMemo/EscrMemo as before.

Parameters:
LARGURA_DADO, 8, data word width in bits (>=1).
LARGURA_END, 8, address width in bits.
PROFUNDIDADE, 256, number of words; must satisfy 1 <= PROFUNDIDADE <= 2^LARGURA_END.
LATENCIA_LEITURA, 1, read latency in cycles; legal values 1 or 2.

Ports:
clk  input  1  single clock, all state updates on rising edge.
reset  input  1  synchronous, active-high; sampled on rising edge of clk.
endereco  input  LARGURA_END  word address.
dado  input  LARGURA_DADO  write data.
EscrMemo  input  1  write request.
LerMemo  input  1  read request.
dadoLido  output  LARGURA_DADO  read data; registered.
valido  output  1  one-cycle pulse, dadoLido valid for an accepted read.
erro  output  1  one-cycle pulse, accepted request had endereco >= PROFUNDIDADE.
ocupado  output  1  high while clear sweep runs; requests ignored.

Behaviour:
- Reset (reset=1 at edge): state<=LIMPA, ptr<=0, ocupado<=1, dadoLido<=0, valido<=0, erro<=0. All in-flight read pipeline stages are flushed. This applies even mid-sweep or mid-read.
- While reset is held, ptr stays 0 and no memory words are written.
- States: LIMPA and OCIOSO.
- LIMPA: on each edge with reset=0, mem[ptr]<=0 and ptr<=ptr+1. On the edge that writes ptr==PROFUNDIDADE-1: state<=OCIOSO, ocupado<=0.
  - The sweep takes exactly PROFUNDIDADE cycles after reset deasserts.
  - EscrMemo/LerMemo are ignored: no write, no valido, no erro.
- OCIOSO, request acceptance: a request is accepted when EscrMemo or LerMemo is 1 at an edge.
- OCIOSO, write: if EscrMemo=1 and endereco<PROFUNDIDADE, mem[endereco]<=dado at that edge.
- OCIOSO, read: if LerMemo=1, the read is accepted.
  - LATENCIA_LEITURA=1: dadoLido and valido=1 appear after the same edge; visible for the following cycle.
  - LATENCIA_LEITURA=2: one extra register stage, so they appear one edge later.
  - Back-to-back reads are fully pipelined: one read accepted per cycle.
- Simultaneous EscrMemo=1 and LerMemo=1, same address: write-first. The write is performed and the read returns the new dado.
- Write followed by read of the same address on the next cycle returns the new value.
- dadoLido holds its last value when valido=0. valido is never high for more than one cycle per accepted read.
- Out of range (endereco >= PROFUNDIDADE):
  - Write is suppressed.
  - Read returns dadoLido=0 with valido=1.
  - erro pulses for one cycle, aligned with valido for reads and with the latency-1 slot for writes.
  - If both requests are out of range, a single erro pulse is issued.
  - When PROFUNDIDADE == 2^LARGURA_END, erro is constantly 0.
- Address arithmetic: ptr is LARGURA_END+1 bits wide to avoid wrap at full depth. No implicit address wrap.

Test Plan:
1. reset=1 for 2 cycles, then 0; default params -> ocupado=1 for exactly 256 cycles, then 0. A read of address 0x37 then returns dadoLido=0x00 with valido=1.
2. After sweep: write 0xA5 to 0x10, next cycle read 0x10 with LATENCIA_LEITURA=1 -> dadoLido=0xA5, valido=1 one edge after the read request, then valido=0.
3. LATENCIA_LEITURA=2: reads of 0x01, 0x02, 0x03 on consecutive cycles (preloaded 0x11, 0x22, 0x33) -> dadoLido=0x11, 0x22, 0x33 on three consecutive cycles starting 2 edges after the first request; valido=1 on each.
4. EscrMemo=1 and LerMemo=1 at address 0x20, dado=0x5C -> dadoLido=0x5C (write-first); a later read of 0x20 also returns 0x5C.
5. PROFUNDIDADE=16, LARGURA_END=5: write 0xFF to 20, then read 20 -> no memory change (full dump after), read gives dadoLido=0 with valido=1 and erro=1; erro also pulses once for the write.
6. During sweep at ptr=100, assert reset one cycle -> ptr restarts at 0 and ocupado stays 1 for 256 more cycles. A write issued during ocupado is dropped: reading that address afterwards returns 0.
